// File: rtl/shiftreg_pkg.sv
// Shared constants and helpers for the left-shifting register.
// Build option: define SHIFTREG_PRESET_EN to enable the parallel-load path.
package shiftreg_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [DEFAULT_WIDTH-1:0] RESET_VALUE = '0;

    typedef enum logic {
        MODE_SHIFT = 1'b0,
        MODE_LOAD  = 1'b1
    } mode_e;

    function automatic mode_e select_mode(input logic load_req);
        return load_req ? MODE_LOAD : MODE_SHIFT;
    endfunction

endpackage

// File: rtl/shiftreg_dff_cell.sv
// Single-bit D flip-flop with asynchronous active-high clear.
// Provides true and complemented outputs.
module shiftreg_dff_cell
    import shiftreg_pkg::*;
(
    input  logic clk,
    input  logic clear,
    input  logic d,
    output logic q,
    output logic qn
);

    logic q_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q_q <= RESET_VALUE[0];
        end else begin
            q_q <= d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: rtl/shift_register_4bit_left.sv
// Left-shifting register: serialInput enters bit 0, MSB is discarded.
// Parallel load is present only when SHIFTREG_PRESET_EN is defined.
module shift_register_4bit_left
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             serialInput,
    input  logic             enablePreset,
    input  logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] notout
);

    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] qn_vec;
    mode_e            load_mode;

`ifdef SHIFTREG_PRESET_EN
    assign load_mode = select_mode(enablePreset);
`else
    // Load controls are kept on the interface but have no effect in this build.
    logic unused_load_ports;
    assign unused_load_ports = ^{enablePreset, preset};
    assign load_mode         = MODE_SHIFT;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic shift_src;
            logic bit_d;

            if (gi == 0) begin : g_lsb
                assign shift_src = serialInput;
            end else begin : g_upper
                assign shift_src = q_vec[gi-1];
            end

            // Unselected source never reaches the flop, so X on it cannot leak.
            always_comb begin
                bit_d = shift_src;
                if (load_mode == MODE_LOAD) begin
                    bit_d = preset[gi];
                end
            end

            shiftreg_dff_cell u_cell (
                .clk   (clockpulse),
                .clear (clear),
                .d     (bit_d),
                .q     (q_vec[gi]),
                .qn    (qn_vec[gi])
            );
        end
    endgenerate

    assign out    = q_vec;
    assign notout = qn_vec;

endmodule

// File: tb/tb_shift_register_4bit_left.sv
// Self-checking bench for shift_register_4bit_left: vector table, corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_shift_register_4bit_left;

    localparam int W = 4;

`ifdef SHIFTREG_PRESET_EN
    localparam bit PRESET_EN = 1'b1;
`else
    localparam bit PRESET_EN = 1'b0;
`endif

    logic         clk;
    logic         clear;
    logic         serial_in;
    logic         enable_preset;
    logic [W-1:0] preset;
    logic [W-1:0] out;
    logic [W-1:0] notout;

    int n_checks = 0;
    int n_fail   = 0;
    int model;

    shift_register_4bit_left #(.WIDTH(W)) dut (
        .clockpulse   (clk),
        .clear        (clear),
        .serialInput  (serial_in),
        .enablePreset (enable_preset),
        .preset       (preset),
        .out          (out),
        .notout       (notout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [W-1:0] pre;
        logic         sin;
        logic [W-1:0] exp_ld;   // expected out when load path is built
        logic [W-1:0] exp_sh;   // expected out when load is ignored
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: out-of-spec value %b, required %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_both(input string name, input logic [W-1:0] exp);
        check({name, ".out"}, out, exp);
        check({name, ".notout"}, notout, ~exp);
    endtask

    function automatic int model_step(input int cur, input logic clr, input logic en,
                                      input logic [W-1:0] pre, input logic sin);
        if (clr) return 0;
        if (en && PRESET_EN) return int'(pre);
        return (cur * 2 + int'(sin)) % (1 << W);
    endfunction

    initial begin
        logic [W-1:0] e;

        vecs[0]  = '{1'b1, 4'b1100, 1'b0, 4'b1100, 4'b0000};
        vecs[1]  = '{1'b0, 4'b0000, 1'b0, 4'b1000, 4'b0000};
        vecs[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b0, 4'b0101, 1'b0, 4'b0000, 4'b0000};
        vecs[4]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 4'b0001};
        vecs[5]  = '{1'b0, 4'b0000, 1'b1, 4'b0011, 4'b0011};
        vecs[6]  = '{1'b0, 4'b1010, 1'b1, 4'b0111, 4'b0111};
        vecs[7]  = '{1'b0, 4'b0000, 1'b1, 4'b1111, 4'b1111};
        vecs[8]  = '{1'b0, 4'b0000, 1'b0, 4'b1110, 4'b1110};
        vecs[9]  = '{1'b0, 4'b0000, 1'b0, 4'b1100, 4'b1100};
        vecs[10] = '{1'b0, 4'b0000, 1'b0, 4'b1000, 4'b1000};
        vecs[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        vecs[12] = '{1'b1, 4'b1100, 1'b1, 4'b1100, 4'b0001};
        vecs[13] = '{1'b0, 4'b0011, 1'b0, 4'b1000, 4'b0010};
        vecs[14] = '{1'b1, 4'b1010, 1'b0, 4'b1010, 4'b0100};
        vecs[15] = '{1'b1, 4'b0110, 1'b1, 4'b0110, 4'b1001};
        vecs[16] = '{1'b0, 4'b0000, 1'b1, 4'b1101, 4'b0011};

        // Clear held from time zero: outputs settle before any edge.
        clear         = 1'b1;
        serial_in     = 1'b0;
        enable_preset = 1'b0;
        preset        = '0;
        #1;
        check_both("reset_t0", 4'b0000);

        // Clear beats a simultaneous load request across edges.
        enable_preset = 1'b1;
        preset        = 4'b1111;
        serial_in     = 1'b1;
        @(posedge clk); #1;
        check_both("clear_vs_load_e1", 4'b0000);
        @(posedge clk); #1;
        check_both("clear_vs_load_e2", 4'b0000);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            clear         = 1'b0;
            enable_preset = vecs[i].en;
            preset        = vecs[i].pre;
            serial_in     = vecs[i].sin;
            @(posedge clk); #1;
            e = PRESET_EN ? vecs[i].exp_ld : vecs[i].exp_sh;
            check_both($sformatf("vec%0d", i), e);
        end

        // Asynchronous clear between edges, then shift from zero.
        @(negedge clk);
        enable_preset = 1'b1;
        preset        = 4'b1010;
        serial_in     = 1'b0;
        @(posedge clk); #1;
        check_both("pre_clear_load", PRESET_EN ? 4'b1010 : 4'b0110);
        #2 clear = 1'b1;
        #1;
        check_both("async_clear", 4'b0000);
        #1 clear = 1'b0;
        @(negedge clk);
        check_both("clear_released", 4'b0000);
        enable_preset = 1'b0;
        serial_in     = 1'b1;
        @(posedge clk); #1;
        check_both("first_edge_after_clear", 4'b0001);

        // Randomized traffic against the arithmetic model.
        model = 1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            clear         = ($urandom_range(0, 15) == 0);
            enable_preset = $urandom_range(0, 1) == 1;
            preset        = W'($urandom);
            serial_in     = $urandom_range(0, 1) == 1;
            if (clear) model = 0;
            #1;
            check_both($sformatf("rnd%0d_mid", n), W'(model));
            model = model_step(model, clear, enable_preset, preset, serial_in);
            @(posedge clk); #1;
            check_both($sformatf("rnd%0d_edge", n), W'(model));
        end

        // Zeros flush the register after WIDTH shifts and it stays empty.
        @(negedge clk);
        clear         = 1'b0;
        enable_preset = 1'b0;
        serial_in     = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        check_both("flush_w", 4'b0000);
        @(posedge clk); #1;
        check_both("flush_hold", 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
